// File: rtl/capture_pkg.sv
// Shared definitions for the capture memory path: default geometry and the
// readout controller state encoding.
package capture_pkg;

  localparam int unsigned NUM_BANK = 96;
  localparam int unsigned DW       = 9;
  localparam int unsigned AW       = 15;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    SEND,
    DONE
  } state_e;

endpackage

// File: rtl/capture_readout_ctrl_serializer.sv
// readout_serializer: holds one full memory read line and emits it as
// OUT_LANES-sample beats on a registered valid/ready stream.
module readout_serializer #(
  parameter int unsigned NUM_BANK  = 96,
  parameter int unsigned DW        = 9,
  parameter int unsigned OUT_LANES = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clear_i,
  input  logic                      load_i,
  input  logic                      last_addr_i,
  input  logic [NUM_BANK*DW-1:0]    line_i,
  input  logic                      out_ready_i,
  output logic                      out_valid_o,
  output logic [OUT_LANES*DW-1:0]   out_data_o,
  output logic                      out_last_o,
  output logic                      drained_o
);
  import capture_pkg::*;

  localparam int unsigned BEATS = NUM_BANK / OUT_LANES;
  localparam int unsigned BW    = OUT_LANES * DW;
  localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [NUM_BANK*DW-1:0] line_q;
  logic [BCW-1:0]         beat_q;
  logic                   last_addr_q;
  logic                   valid_q;
  logic [BW-1:0]          data_q;
  logic                   olast_q;

  logic                   xfer;
  logic                   final_beat;
  logic [BCW-1:0]         beat_nxt;

  // Handshake decode and next-beat index.
  always_comb begin
    xfer       = valid_q && out_ready_i;
    final_beat = (beat_q == BCW'(BEATS - 1));
    beat_nxt   = beat_q + 1'b1;
    drained_o  = xfer && final_beat && !clear_i;
  end

  // Line buffer, beat counter and registered output stage; clear beats load and transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      line_q      <= '0;
      beat_q      <= '0;
      last_addr_q <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      olast_q     <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      olast_q <= 1'b0;
    end else if (load_i) begin
      line_q      <= line_i;
      beat_q      <= '0;
      last_addr_q <= last_addr_i;
      valid_q     <= 1'b1;
      data_q      <= line_i[BW-1:0];
      olast_q     <= last_addr_i && (BEATS == 1);
    end else if (xfer) begin
      if (final_beat) begin
        valid_q <= 1'b0;
        olast_q <= 1'b0;
      end else begin
        beat_q  <= beat_nxt;
        data_q  <= line_q[int'(beat_nxt)*BW +: BW];
        olast_q <= last_addr_q && (beat_nxt == BCW'(BEATS - 1));
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = olast_q;

endmodule

// File: rtl/capture_readout_ctrl.sv
// capture_readout_ctrl: reads back the capture memory one address at a time
// after a capture, and streams each wide read line out as narrow beats.
module capture_readout_ctrl #(
  parameter int unsigned NUM_BANK  = capture_pkg::NUM_BANK,
  parameter int unsigned DW        = capture_pkg::DW,
  parameter int unsigned AW        = capture_pkg::AW,
  parameter int unsigned OUT_LANES = 8,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [AW-1:0]             start_addr,
  input  logic [AW:0]               rd_count,
  input  logic                      abort,
  input  logic                      wr_active,
  output logic [NUM_BANK-1:0]       rd_cen,
  output logic [NUM_BANK-1:0]       rd_wen,
  output logic [AW*NUM_BANK-1:0]    raddr,
  input  logic [DW*NUM_BANK-1:0]    data_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW*OUT_LANES-1:0]   out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);
  import capture_pkg::*;

  state_e                 state_q;
  logic [AW-1:0]          cur_addr_q;
  logic [AW:0]            remaining_q;
  logic [2:0]             wait_q;
  logic [NUM_BANK-1:0]    rd_cen_q;
  logic [AW*NUM_BANK-1:0] raddr_q;
  logic                   busy_q;
  logic                   done_q;

  logic                   ser_load;
  logic                   ser_clear;
  logic                   last_addr;
  logic                   drained;

  // Serializer control: load the line in the cycle read data is valid.
  always_comb begin
    ser_load  = (state_q == RD_WAIT) && (wait_q == 3'(RD_LAT)) && !abort;
    ser_clear = abort && (state_q != IDLE);
    last_addr = (remaining_q == (AW+1)'(1));
  end

  // Readout FSM with address/remaining counters and registered memory-side outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      wait_q      <= '0;
      rd_cen_q    <= '1;
      raddr_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rd_cen_q <= '1;
      done_q   <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              busy_q <= 1'b1;
              if (rd_count == '0) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                cur_addr_q  <= start_addr;
                remaining_q <= rd_count;
                state_q     <= RD_REQ;
              end
            end
          end
          RD_REQ: begin
            if (!wr_active) begin
              rd_cen_q <= '0;
              raddr_q  <= {NUM_BANK{cur_addr_q}};
              wait_q   <= '0;
              state_q  <= RD_WAIT;
            end
          end
          RD_WAIT: begin
            // wait_q is 0 in the cycle the request is visible to the memory
            if (wait_q == 3'(RD_LAT)) begin
              state_q <= SEND;
            end else begin
              wait_q <= wait_q + 3'd1;
            end
          end
          SEND: begin
            if (drained) begin
              remaining_q <= remaining_q - (AW+1)'(1);
              cur_addr_q  <= cur_addr_q + AW'(1);
              if (last_addr) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= RD_REQ;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  readout_serializer #(
    .NUM_BANK  (NUM_BANK),
    .DW        (DW),
    .OUT_LANES (OUT_LANES)
  ) u_ser (
    .clk         (clk),
    .rstn        (rstn),
    .clear_i     (ser_clear),
    .load_i      (ser_load),
    .last_addr_i (last_addr),
    .line_i      (data_out),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .drained_o   (drained)
  );

  assign rd_cen = rd_cen_q;
  assign rd_wen = '1;
  assign raddr  = raddr_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_capture_readout_ctrl.sv
// Bench for capture_readout_ctrl: behavioural memory plus a readout model
// that predicts request addresses and beat contents from the address list.
module tb_capture_readout_ctrl;

  localparam int NB    = 96;
  localparam int DW    = 9;
  localparam int AW    = 15;
  localparam int OL    = 8;
  localparam int BEATS = NB / OL;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [AW-1:0]     start_addr;
  logic [AW:0]       rd_count;
  logic              abort;
  logic              wr_active;
  logic [NB-1:0]     rd_cen;
  logic [NB-1:0]     rd_wen;
  logic [AW*NB-1:0]  raddr;
  logic [DW*NB-1:0]  data_out;
  logic              out_valid;
  logic              out_ready;
  logic [DW*OL-1:0]  out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  capture_readout_ctrl #(
    .NUM_BANK  (NB),
    .DW        (DW),
    .AW        (AW),
    .OUT_LANES (OL),
    .RD_LAT    (1)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .start_addr (start_addr),
    .rd_count   (rd_count),
    .abort      (abort),
    .wr_active  (wr_active),
    .rd_cen     (rd_cen),
    .rd_wen     (rd_wen),
    .raddr      (raddr),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  // Memory: one-cycle read latency, bank b holds b ^ addr[8:0]; garbage otherwise.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (rd_cen[b] === 1'b0)
        data_out[b*DW +: DW] <= DW'(b) ^ raddr[b*AW +: DW];
      else
        data_out[b*DW +: DW] <= DW'($urandom);
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  logic [AW-1:0] m_base;
  int            m_n;
  int            m_req;
  int            m_beat;
  int            n_done;
  int            done_cyc;
  int            last_xfer_cyc;
  int            first_req_cyc;
  int            start_cyc;
  bit            rnd_ready = 0;
  bit            rnd_wr = 0;
  bit            prev_stall = 0;
  logic [DW*OL-1:0] prev_data;
  logic          prev_last;
  logic          wr_prev = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: entered at a negedge with this cycle's inputs set.
  task automatic cyc();
    logic [AW-1:0]    a;
    logic [AW-1:0]    bad;
    logic [DW*OL-1:0] exp;
    int               k;
    if (rnd_ready) out_ready = ($urandom_range(0, 1) == 1);
    if (rnd_wr)    wr_active = ($urandom_range(0, 3) == 0);
    if (rd_cen !== {NB{1'b1}}) begin
      a   = m_base + AW'(m_req);
      bad = a;
      for (int b = 0; b < NB; b++)
        if (raddr[b*AW +: AW] !== a) bad = raddr[b*AW +: AW];
      check("rd_cen_all_low", rd_cen, {NB{1'b0}});
      check("rd_wen_high", rd_wen, {NB{1'b1}});
      check("req_while_wr", wr_prev, 0);
      check("raddr_fields", bad, a);
      if (m_req == 0) first_req_cyc = cyc_n;
      m_req++;
      check("req_count_bound", m_req <= m_n, 1);
    end
    if (prev_stall) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, prev_data);
      check("stall_last", out_last, prev_last);
    end
    if (out_valid && out_ready && !abort) begin
      check("beat_in_range", m_beat < m_n * BEATS, 1);
      a = m_base + AW'(m_beat / BEATS);
      k = m_beat % BEATS;
      for (int l = 0; l < OL; l++)
        exp[l*DW +: DW] = DW'(k * OL + l) ^ a[DW-1:0];
      check("beat_data", out_data, exp);
      check("beat_last", out_last, m_beat == m_n * BEATS - 1);
      if (m_beat == m_n * BEATS - 1) last_xfer_cyc = cyc_n;
      m_beat++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc_n;
    end
    prev_stall = out_valid && !out_ready && !abort;
    prev_data  = out_data;
    prev_last  = out_last;
    wr_prev    = wr_active;
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic begin_ro(input logic [AW-1:0] addr, input int n);
    m_base = addr; m_n = n; m_req = 0; m_beat = 0; n_done = 0;
    done_cyc = -1; last_xfer_cyc = -1; first_req_cyc = -1;
    start_addr = addr;
    rd_count   = (AW+1)'(n);
    start      = 1'b1;
    start_cyc  = cyc_n;
    cyc();
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic finish_ro();
    int t = 0;
    while (done_cyc < 0 && t < 4000) begin
      cyc();
      t++;
    end
    check("done_seen", done_cyc >= 0, 1);
    check("req_total", m_req, m_n);
    check("beat_total", m_beat, m_n * BEATS);
    if (m_n > 0) check("done_after_last", done_cyc, last_xfer_cyc + 1);
    else         check("done_after_start", done_cyc, start_cyc + 1);
    repeat (5) cyc();
    check("idle_busy", busy, 0);
    check("no_extra_req", m_req, m_n);
    check("done_once", n_done, 1);
  endtask

  initial begin
    int t;
    int fall_cyc;
    rstn = 1'b0; start = 1'b0; start_addr = '0; rd_count = '0;
    abort = 1'b0; wr_active = 1'b0; out_ready = 1'b1;
    m_base = '0; m_n = 0; m_req = 0; m_beat = 0; n_done = 0;
    repeat (2) @(negedge clk);
    check("rst_rd_cen", rd_cen, {NB{1'b1}});
    check("rst_rd_wen", rd_wen, {NB{1'b1}});
    check("rst_raddr_lo", raddr[127:0], 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Single address, always ready
    begin_ro(15'h0010, 1);
    finish_ro();
    check("req_latency", first_req_cyc, start_cyc + 2);

    // Address wrap, plus a start pulse while busy that must be ignored
    begin_ro(15'h7FFE, 3);
    repeat (3) cyc();
    start = 1'b1; start_addr = 15'h0111; rd_count = 16'd5;
    cyc();
    start = 1'b0;
    finish_ro();

    // Random backpressure, then random backpressure with random write activity
    rnd_ready = 1;
    begin_ro(AW'($urandom), 2);
    finish_ro();
    rnd_wr = 1;
    begin_ro(AW'($urandom), 3);
    finish_ro();
    rnd_ready = 0; rnd_wr = 0; out_ready = 1'b1; wr_active = 1'b0;
    repeat (2) cyc();

    // Write activity holds off the request
    wr_active = 1'b1;
    begin_ro(15'h1234, 1);
    repeat (20) cyc();
    check("held_no_req", m_req, 0);
    wr_active = 1'b0;
    fall_cyc  = cyc_n;
    finish_ro();
    check("req_after_wr_fall", first_req_cyc, fall_cyc + 1);

    // Zero-length readout
    begin_ro(15'h0055, 0);
    finish_ro();

    // Abort at beat 5 with ready high
    begin_ro(15'h0300, 2);
    t = 0;
    while (m_beat < 5 && t < 200) begin
      cyc();
      t++;
    end
    check("reach_beat5", m_beat, 5);
    check("beat5_valid", out_valid, 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_rd_cen", rd_cen, {NB{1'b1}});
    repeat (5) cyc();
    check("abort_no_done", n_done, 0);
    check("abort_reqs", m_req, 1);
    check("abort_beats", m_beat, 5);
    begin_ro(15'h0400, 1);
    finish_ro();

    // Abort and start together in IDLE: nothing starts
    m_n = 0; m_req = 0; m_beat = 0; n_done = 0;
    start = 1'b1; abort = 1'b1; start_addr = 15'h0500; rd_count = 16'd1;
    cyc();
    start = 1'b0; abort = 1'b0;
    repeat (4) cyc();
    check("abort_start_busy", busy, 0);
    check("abort_start_req", m_req, 0);
    check("abort_start_done", n_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
